// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the multi-channel DMA engine
// Purpose: engine FSM state encoding and the word-to-byte address shift.
// Ports: none (package).
package dma_pkg;
   typedef enum logic [2:0] {IDLE, ARB, READ, WAIT, WRITE, RET} state_t;
   localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/dma_rr_arbiter.sv
// rtl/dma_rr_arbiter.sv - round-robin grant of one requesting channel
// Purpose: picks the lowest-index requester at or after ptr_i, wrapping around.
// Ports:
//   req_i   in   NUM_CH  request vector
//   ptr_i   in   IW      round-robin start index
//   grant_o out  NUM_CH  one-hot grant
//   idx_o   out  IW      index of granted channel
//   any_o   out  1       some request was granted
module dma_rr_arbiter #(
   parameter int NUM_CH = 2,
   parameter int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IW-1:0]     ptr_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [IW-1:0]     idx_o,
   output logic              any_o
);

   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      cand    = '0;
      found   = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = IW'((int'(ptr_i) + k) % NUM_CH);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            idx_o = cand;
         end
      end
      if (found) grant_o[idx_o] = 1'b1;
      any_o = found;
   end

endmodule

// File: rtl/dma_mc_engine.sv
// rtl/dma_mc_engine.sv - multi-channel chunked DMA read/write engine
// Purpose: NUM_CH channels share one read/write engine; each grant moves one
//   chunk of up to BURST_W words, with round-robin arbitration between chunks.
//   Optional feature macro: DMA_ABORT_EN (adds the ch_abort port).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   ch_en/ch_src/ch_dst/ch_len per-channel enable, byte addresses, word length
//   rd_req/rd_addr            read-chunk request and source address
//   wr_req/wr_addr            write-chunk request and destination address
//   xfer_len                  words in the current chunk
//   rd_done/wr_done           chunk completion pulses from the master
//   fifo_full/fifo_empty      data FIFO status
//   irq                       per-channel completion (level)
//   ch_abort                  per-channel abort pulse (DMA_ABORT_EN only)
module dma_mc_engine
   import dma_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 32,
   parameter int LEN_W   = 16,
   parameter int BURST_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_en,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_src,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_dst,
   input  logic [NUM_CH*LEN_W-1:0]    ch_len,
   output logic                       rd_req,
   output logic [ADDR_W-1:0]          rd_addr,
   output logic                       wr_req,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [$clog2(BURST_W):0]   xfer_len,
   input  logic                       rd_done,
   input  logic                       wr_done,
   input  logic                       fifo_full,
   input  logic                       fifo_empty,
   output logic [NUM_CH-1:0]          irq
`ifdef DMA_ABORT_EN
   ,
   input  logic [NUM_CH-1:0]          ch_abort
`endif
);

   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int XW = $clog2(BURST_W) + 1;
   localparam int OW = LEN_W + 1;

   state_t              state_q, state_d;
   logic [IW-1:0]       cur_q, cur_d, rr_q, rr_d;
   logic [XW-1:0]       xfer_q, xfer_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [OW-1:0]       off_q [NUM_CH];
   logic [OW-1:0]       off_d [NUM_CH];
   logic [NUM_CH-1:0]   irq_q, irq_d;
   logic                drop_q, drop_d, abort_q, abort_d;

   logic [ADDR_W-1:0]   src_w [NUM_CH];
   logic [ADDR_W-1:0]   dst_w [NUM_CH];
   logic [OW-1:0]       len_w [NUM_CH];
   logic [NUM_CH-1:0]   elig, elig_nxt, grant;
   logic [IW-1:0]       gnt_idx;
   logic                gnt_any, abort_cur;
   logic [ADDR_W-1:0]   sel_src, sel_dst;
   logic [OW-1:0]       sel_len, sel_off, rem;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         src_w[i] = ch_src[i*ADDR_W +: ADDR_W];
         dst_w[i] = ch_dst[i*ADDR_W +: ADDR_W];
         len_w[i] = {1'b0, ch_len[i*LEN_W +: LEN_W]};
         elig[i]  = ch_en[i] && !irq_q[i] && (off_q[i] < len_w[i]);
      end
   end

   dma_rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
      .req_i   (elig),
      .ptr_i   (rr_q),
      .grant_o (grant),
      .idx_o   (gnt_idx),
      .any_o   (gnt_any)
   );

   // One-hot grant selects the winning channel's parameters.
   always_comb begin
      sel_src = '0;
      sel_dst = '0;
      sel_len = '0;
      sel_off = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) begin
            sel_src |= src_w[i];
            sel_dst |= dst_w[i];
            sel_len |= len_w[i];
            sel_off |= off_q[i];
         end
      end
      rem = sel_len - sel_off;
   end

`ifdef DMA_ABORT_EN
   logic in_chunk;
   assign in_chunk  = state_q inside {READ, WAIT, WRITE, RET};
   assign abort_cur = ch_abort[cur_q] && (state_q inside {READ, WAIT, WRITE});
`else
   assign abort_cur = 1'b0;
`endif

   // Per-channel bookkeeping. ch_en low is applied last so it overrides any
   // irq set in the same cycle.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         off_d[i] = off_q[i];
         irq_d[i] = irq_q[i];
         if (ch_en[i] && len_w[i] == '0) irq_d[i] = 1'b1;
         if (state_q == RET && cur_q == IW'(i) && !abort_q) begin
            if (drop_q) begin
               off_d[i] = '0;
            end else begin
               off_d[i] = off_q[i] + OW'(xfer_q);
               if (off_d[i] >= len_w[i]) irq_d[i] = 1'b1;
            end
         end
`ifdef DMA_ABORT_EN
         if (ch_abort[i] && !(in_chunk && cur_q == IW'(i))) off_d[i] = '0;
`endif
         if (!ch_en[i]) begin
            off_d[i] = '0;
            irq_d[i] = 1'b0;
         end
         elig_nxt[i] = ch_en[i] && !irq_d[i] && (off_d[i] < len_w[i]);
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      rr_d      = rr_q;
      xfer_d    = xfer_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      drop_d    = drop_q;
      abort_d   = abort_q;
      rd_req    = 1'b0;
      wr_req    = 1'b0;
      case (state_q)
         IDLE: if (|elig) state_d = ARB;
         ARB: begin
            if (gnt_any) begin
               // Addresses and length are latched so they stay stable even if
               // the CSRs change while the chunk is in flight.
               cur_d     = gnt_idx;
               xfer_d    = (32'(rem) > 32'(BURST_W)) ? XW'(BURST_W) : XW'(rem);
               rd_addr_d = sel_src + (ADDR_W'(sel_off) << WORD_SHIFT);
               wr_addr_d = sel_dst + (ADDR_W'(sel_off) << WORD_SHIFT);
               drop_d    = 1'b0;
               abort_d   = 1'b0;
               state_d   = READ;
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            rd_req = 1'b1;
            if (rd_done || fifo_full) state_d = WAIT;
         end
         WAIT: begin
            wr_req = 1'b1;
            if (!fifo_empty) state_d = WRITE;
         end
         WRITE: begin
            wr_req = 1'b1;
            if (wr_done || fifo_empty) state_d = RET;
         end
         RET: begin
            rr_d    = IW'((int'(cur_q) + 1) % NUM_CH);
            state_d = (|elig_nxt) ? ARB : IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Granted channel disabled mid-chunk: finish the chunk, then restart it from zero.
      if ((state_q inside {READ, WAIT, WRITE}) && !ch_en[cur_q]) drop_d = 1'b1;
      if (abort_cur) begin
         state_d = RET;
         abort_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cur_q     <= '0;
         rr_q      <= '0;
         xfer_q    <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         irq_q     <= '0;
         drop_q    <= 1'b0;
         abort_q   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) off_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         rr_q      <= rr_d;
         xfer_q    <= xfer_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         irq_q     <= irq_d;
         drop_q    <= drop_d;
         abort_q   <= abort_d;
         for (int i = 0; i < NUM_CH; i++) off_q[i] <= off_d[i];
      end
   end

   assign rd_addr  = rd_addr_q;
   assign wr_addr  = wr_addr_q;
   assign xfer_len = xfer_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_dma_mc_engine.sv
// tb/tb_dma_mc_engine.sv - scoreboard bench for dma_mc_engine
module tb_dma_mc_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ch_en;
   logic [63:0] ch_src, ch_dst;
   logic [31:0] ch_len;
   logic        rd_req, wr_req, rd_done, wr_done, fifo_full, fifo_empty;
   logic [31:0] rd_addr, wr_addr;
   logic [4:0]  xfer_len;
   logic [1:0]  irq;
`ifdef DMA_ABORT_EN
   logic [1:0]  ch_abort;
`endif

   typedef struct packed {
      logic [31:0] rd;
      logic [31:0] wr;
      logic [4:0]  len;
   } chunk_t;

   chunk_t exp_q[$];
   int     n_cmp = 0;
   int     n_bad = 0;

   always #5 clk = ~clk;

   dma_mc_engine #(.NUM_CH(2), .ADDR_W(32), .LEN_W(16), .BURST_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .ch_en      (ch_en),
      .ch_src     (ch_src),
      .ch_dst     (ch_dst),
      .ch_len     (ch_len),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .xfer_len   (xfer_len),
      .rd_done    (rd_done),
      .wr_done    (wr_done),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .irq        (irq)
`ifdef DMA_ABORT_EN
      ,
      .ch_abort   (ch_abort)
`endif
   );

   task automatic drive_idle();
      ch_en = '0; ch_src = '0; ch_dst = '0; ch_len = '0;
      rd_done = 0; wr_done = 0; fifo_full = 0; fifo_empty = 1;
`ifdef DMA_ABORT_EN
      ch_abort = '0;
`endif
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic set_ch(input int ch, input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
      ch_src[ch*32 +: 32] = s;
      ch_dst[ch*32 +: 32] = d;
      ch_len[ch*16 +: 16] = l;
   endtask

   task automatic push_exp(input logic [31:0] r, input logic [31:0] w, input logic [4:0] l);
      chunk_t e;
      e.rd = r; e.wr = w; e.len = l;
      exp_q.push_back(e);
   endtask

   // Waits (bounded) for rd_req; waited = negedges elapsed minus one, -1 on timeout.
   task automatic wait_rd(output int waited);
      waited = -1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (rd_req) begin
            waited = n;
            break;
         end
      end
   endtask

   // Serves one chunk as master + FIFO; returns at a negedge while the engine is in RET.
   task automatic do_chunk(output chunk_t obs, output int waited);
      obs = '0;
      wait_rd(waited);
      if (waited < 0) return;
      obs.rd = rd_addr; obs.wr = wr_addr; obs.len = xfer_len;
      rd_done = 1;
      @(negedge clk); rd_done = 0; fifo_empty = 0;
      @(negedge clk); wr_done = 1;
      @(negedge clk); wr_done = 0; fifo_empty = 1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      @(negedge clk);
      n_cmp++;
      if ({rd_req, wr_req, rd_addr, wr_addr, xfer_len, irq} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got rd_req=%b wr_req=%b rd_addr=%h wr_addr=%h xfer_len=%0d irq=%b, expected all zero",
                  rd_req, wr_req, rd_addr, wr_addr, xfer_len, irq);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      chunk_t obs, e;
      int w;
      apply_reset();
      set_ch(0, 32'h1000, 32'h2000, 16'd40);
      push_exp(32'h1000, 32'h2000, 5'd16);
      push_exp(32'h1040, 32'h2040, 5'd16);
      push_exp(32'h1080, 32'h2080, 5'd8);
      ch_en = 2'b01;
      for (int c = 0; c < 3; c++) begin
         do_chunk(obs, w);
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL single_chunk%0d: got rd=%h wr=%h len=%0d, expected rd=%h wr=%h len=%0d",
                     c, obs.rd, obs.wr, obs.len, e.rd, e.wr, e.len);
         end
         n_cmp++;
         if (w !== 1) begin
            n_bad++;
            $display("FAIL single_latency%0d: got %0d idle cycles before rd_req, expected 1", c, w);
         end
         if (c == 1) begin
            n_cmp++;
            if (irq !== 2'b00) begin
               n_bad++;
               $display("FAIL single_irq_early: got irq=%b, expected 00", irq);
            end
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({irq, rd_req} !== 3'b010) begin
         n_bad++;
         $display("FAIL single_irq_done: got irq=%b rd_req=%b, expected irq=01 rd_req=0", irq, rd_req);
      end
      ch_en = 2'b00;
      @(negedge clk);
      n_cmp++;
      if (irq !== 2'b00) begin
         n_bad++;
         $display("FAIL single_irq_clear: got irq=%b, expected 00", irq);
      end
   endtask

   task automatic test_round_robin();
      chunk_t obs, e;
      int w;
      apply_reset();
      set_ch(0, 32'h1000, 32'h2000, 16'd32);
      set_ch(1, 32'h3000, 32'h4000, 16'd32);
      push_exp(32'h1000, 32'h2000, 5'd16);
      push_exp(32'h3000, 32'h4000, 5'd16);
      push_exp(32'h1040, 32'h2040, 5'd16);
      push_exp(32'h3040, 32'h4040, 5'd16);
      ch_en = 2'b11;
      for (int c = 0; c < 4; c++) begin
         do_chunk(obs, w);
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL rr_chunk%0d: got rd=%h wr=%h len=%0d, expected rd=%h wr=%h len=%0d",
                     c, obs.rd, obs.wr, obs.len, e.rd, e.wr, e.len);
         end
         if (c >= 2) begin
            @(negedge clk);
            n_cmp++;
            if (irq !== ((c == 2) ? 2'b01 : 2'b11)) begin
               n_bad++;
               $display("FAIL rr_irq%0d: got irq=%b, expected %b", c, irq, (c == 2) ? 2'b01 : 2'b11);
            end
         end
      end
   endtask

   task automatic test_zero_len();
      int seen = 0;
      apply_reset();
      set_ch(1, 32'h7000, 32'h8000, 16'd0);
      ch_en = 2'b10;
      @(negedge clk);
      n_cmp++;
      if (irq !== 2'b10) begin
         n_bad++;
         $display("FAIL zero_len_irq: got irq=%b, expected 10", irq);
      end
      for (int n = 0; n < 10; n++) begin
         if (rd_req) seen++;
         @(negedge clk);
      end
      n_cmp++;
      if (seen !== 0) begin
         n_bad++;
         $display("FAIL zero_len_traffic: got %0d rd_req cycles, expected 0", seen);
      end
   endtask

   task automatic test_fifo_flags();
      chunk_t obs, e;
      int w;
      apply_reset();
      set_ch(0, 32'h5000, 32'h6000, 16'd8);
      push_exp(32'h5000, 32'h6000, 5'd8);
      ch_en = 2'b01;
      wait_rd(w);
      obs.rd = rd_addr; obs.wr = wr_addr; obs.len = xfer_len;
      e = exp_q.pop_front();
      n_cmp++;
      if (w < 0 || obs !== e) begin
         n_bad++;
         $display("FAIL fifo_chunk: got rd=%h wr=%h len=%0d (wait %0d), expected rd=%h wr=%h len=%0d",
                  obs.rd, obs.wr, obs.len, w, e.rd, e.wr, e.len);
      end
      fifo_full = 1;
      @(negedge clk);
      fifo_full = 0;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if ({rd_req, wr_req} !== 2'b01) begin
            n_bad++;
            $display("FAIL fifo_wait%0d: got rd_req=%b wr_req=%b, expected 0 1", k, rd_req, wr_req);
         end
         if (k == 0) @(negedge clk);
      end
      fifo_empty = 0;
      @(negedge clk);
      n_cmp++;
      if ({wr_req, wr_addr} !== {1'b1, 32'h6000}) begin
         n_bad++;
         $display("FAIL fifo_write: got wr_req=%b wr_addr=%h, expected 1 00006000", wr_req, wr_addr);
      end
      fifo_empty = 1;
      @(negedge clk);
      n_cmp++;
      if ({rd_req, wr_req} !== 2'b00) begin
         n_bad++;
         $display("FAIL fifo_ret: got rd_req=%b wr_req=%b, expected 0 0", rd_req, wr_req);
      end
      @(negedge clk);
      n_cmp++;
      if (irq !== 2'b01) begin
         n_bad++;
         $display("FAIL fifo_irq: got irq=%b, expected 01", irq);
      end
   endtask

   task automatic test_disable_mid();
      chunk_t obs, e;
      int w;
      apply_reset();
      set_ch(0, 32'h1000, 32'h2000, 16'd40);
      push_exp(32'h1000, 32'h2000, 5'd16);
      push_exp(32'h1040, 32'h2040, 5'd16);
      push_exp(32'h1000, 32'h2000, 5'd16);
      ch_en = 2'b01;
      do_chunk(obs, w);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
         n_bad++;
         $display("FAIL dis_chunk0: got rd=%h len=%0d, expected rd=%h len=%0d", obs.rd, obs.len, e.rd, e.len);
      end
      wait_rd(w);
      obs.rd = rd_addr; obs.wr = wr_addr; obs.len = xfer_len;
      e = exp_q.pop_front();
      n_cmp++;
      if (w < 0 || obs !== e) begin
         n_bad++;
         $display("FAIL dis_chunk1: got rd=%h len=%0d (wait %0d), expected rd=%h len=%0d", obs.rd, obs.len, w, e.rd, e.len);
      end
      rd_done = 1;
      @(negedge clk); rd_done = 0; fifo_empty = 0;
      @(negedge clk); ch_en = 2'b00;
      @(negedge clk);
      n_cmp++;
      if ({wr_req, wr_addr} !== {1'b1, 32'h2040}) begin
         n_bad++;
         $display("FAIL dis_write_hold: got wr_req=%b wr_addr=%h, expected 1 00002040", wr_req, wr_addr);
      end
      wr_done = 1;
      @(negedge clk); wr_done = 0; fifo_empty = 1;
      @(negedge clk);
      n_cmp++;
      if ({irq, rd_req} !== 3'b000) begin
         n_bad++;
         $display("FAIL dis_idle: got irq=%b rd_req=%b, expected 00 0", irq, rd_req);
      end
      ch_en = 2'b01;
      do_chunk(obs, w);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
         n_bad++;
         $display("FAIL dis_restart: got rd=%h len=%0d, expected rd=%h len=%0d", obs.rd, obs.len, e.rd, e.len);
      end
   endtask

`ifdef DMA_ABORT_EN
   task automatic test_abort();
      chunk_t obs, e;
      int w;
      apply_reset();
      set_ch(0, 32'h1000, 32'h2000, 16'd32);
      set_ch(1, 32'h3000, 32'h4000, 16'd16);
      push_exp(32'h3000, 32'h4000, 5'd16);
      ch_en = 2'b11;
      wait_rd(w);
      n_cmp++;
      if (w < 0 || rd_addr !== 32'h1000) begin
         n_bad++;
         $display("FAIL abort_first: got rd_addr=%h (wait %0d), expected 00001000", rd_addr, w);
      end
      ch_abort = 2'b01;
      @(negedge clk);
      ch_abort = 2'b00;
      n_cmp++;
      if ({rd_req, wr_req} !== 2'b00) begin
         n_bad++;
         $display("FAIL abort_drop: got rd_req=%b wr_req=%b, expected 0 0", rd_req, wr_req);
      end
      do_chunk(obs, w);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
         n_bad++;
         $display("FAIL abort_next: got rd=%h len=%0d, expected rd=%h len=%0d", obs.rd, obs.len, e.rd, e.len);
      end
      n_cmp++;
      if (irq[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_irq: got irq[0]=%b, expected 0", irq[0]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_zero_len();
      test_fifo_flags();
      test_disable_mid();
`ifdef DMA_ABORT_EN
      test_abort();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
